// File: rtl/dac_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : dac_frame_rx
//  Purpose  : Receives 16-bit serial frames from a DAC-style transmitter on
//             two chip-select channels, validates length, command nibble and
//             tail bits, and publishes the payload byte of each good frame.
//  Ports    : clk          system clock (rising edge)
//             CS           asynchronous active-low reset
//             ClkDac       serial clock, asynchronous to clk
//             CsDac[1:0]   channel selects, active-high (bit0 = ch0)
//             dataDac      serial data, MSB first, sampled on rising ClkDac
//             err_clr      synchronous clear of the sticky error flags
//             data_out     {ch1 byte, ch0 byte}, last good value per channel
//             frame_valid  one-clk pulse per accepted frame
//             frame_ch     channel of the last accepted frame
//             err_len/err_cmd/err_sel  sticky error flags
//             frame_cnt    accepted-frame counter, wraps 255->0
//  Revision : 1.0  initial release
// ============================================================================
module dac_frame_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [3:0]  CMD0        = 4'b0111,
    parameter logic [3:0]  CMD1        = 4'b1111
) (
    input  logic        clk,
    input  logic        CS,
    input  logic        ClkDac,
    input  logic [1:0]  CsDac,
    input  logic        dataDac,
    input  logic        err_clr,
    output logic [15:0] data_out,
    output logic        frame_valid,
    output logic        frame_ch,
    output logic        err_len,
    output logic        err_cmd,
    output logic        err_sel,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. flush_q tracks how far valid pin samples have
    // propagated since reset, so the reset value of the chain is never
    // mistaken for a genuine all-low chip select.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]       clk_sync_q;
    logic [SYNC_STAGES-1:0]       dat_sync_q;
    logic [SYNC_STAGES-1:0][1:0]  cs_sync_q;
    logic [SYNC_STAGES-1:0]       flush_q;

    always_ff @(posedge clk or negedge CS) begin
        if (!CS) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            cs_sync_q  <= '0;
            flush_q    <= '0;
        end else begin
            clk_sync_q[0] <= ClkDac;
            dat_sync_q[0] <= dataDac;
            cs_sync_q[0]  <= CsDac;
            flush_q[0]    <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_q[i] <= clk_sync_q[i-1];
                dat_sync_q[i] <= dat_sync_q[i-1];
                cs_sync_q[i]  <= cs_sync_q[i-1];
                flush_q[i]    <= flush_q[i-1];
            end
        end
    end

    logic       w_clk_s;
    logic       w_dat_s;
    logic [1:0] w_cs_s;
    logic       w_cs_valid;

    assign w_clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign w_dat_s    = dat_sync_q[SYNC_STAGES-1];
    assign w_cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign w_cs_valid = flush_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q,       state_d;
    logic        ch_q,          ch_d;
    logic [4:0]  bit_cnt_q,     bit_cnt_d;
    logic [15:0] shift_q,       shift_d;
    logic        clk_prev_q,    clk_prev_d;
    // Blocks a new frame start until the selects have been seen all-low;
    // a frame must begin with a genuine rising select.
    logic        cs_wait_q,     cs_wait_d;
    logic [15:0] data_out_q,    data_out_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_ch_q,    frame_ch_d;
    logic        err_len_q,     err_len_d;
    logic        err_cmd_q,     err_cmd_d;
    logic        err_sel_q,     err_sel_d;
    logic [7:0]  frame_cnt_q,   frame_cnt_d;

    logic        w_set_len;
    logic        w_set_cmd;
    logic        w_set_sel;
    logic        w_clk_rise;
    logic [1:0]  w_active;
    logic [3:0]  w_cmd_exp;

    assign w_clk_rise = w_clk_s & ~clk_prev_q;
    assign w_active   = ch_q ? 2'b10 : 2'b01;
    assign w_cmd_exp  = ch_q ? CMD1 : CMD0;

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        clk_prev_d    = w_clk_s;
        cs_wait_d     = cs_wait_q;
        data_out_d    = data_out_q;
        frame_valid_d = 1'b0;
        frame_ch_d    = frame_ch_q;
        frame_cnt_d   = frame_cnt_q;
        w_set_len     = 1'b0;
        w_set_cmd     = 1'b0;
        w_set_sel     = 1'b0;

        if (w_cs_valid && (w_cs_s == 2'b00)) begin
            cs_wait_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (w_cs_valid) begin
                    if (w_cs_s == 2'b11) begin
                        w_set_sel = 1'b1;
                        cs_wait_d = 1'b1;
                    end else if (!cs_wait_q && (w_cs_s != 2'b00)) begin
                        ch_d      = w_cs_s[1];
                        bit_cnt_d = 5'd0;
                        shift_d   = 16'h0000;
                        state_d   = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (w_cs_s == 2'b00) begin
                    state_d = CHECK;
                end else if (w_cs_s != w_active) begin
                    // Select pattern changed mid-frame: drop it and wait
                    // for the selects to go all-low before restarting.
                    w_set_sel = 1'b1;
                    cs_wait_d = 1'b1;
                    state_d   = IDLE;
                end else if (w_clk_rise) begin
                    shift_d = {shift_q[14:0], w_dat_s};
                    if (bit_cnt_q != 5'd17) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            CHECK: begin
                state_d = IDLE;
                if (bit_cnt_q != 5'd16) begin
                    w_set_len = 1'b1;
                end else if ((shift_q[15:12] != w_cmd_exp) || (shift_q[3:0] != 4'h0)) begin
                    w_set_cmd = 1'b1;
                end else begin
                    if (ch_q) begin
                        data_out_d[15:8] = shift_q[11:4];
                    end else begin
                        data_out_d[7:0]  = shift_q[11:4];
                    end
                    frame_ch_d    = ch_q;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A set event on the same clk as err_clr wins.
        err_len_d = (err_len_q & ~err_clr) | w_set_len;
        err_cmd_d = (err_cmd_q & ~err_clr) | w_set_cmd;
        err_sel_d = (err_sel_q & ~err_clr) | w_set_sel;
    end

    always_ff @(posedge clk or negedge CS) begin
        if (!CS) begin
            state_q       <= IDLE;
            ch_q          <= 1'b0;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 16'h0000;
            clk_prev_q    <= 1'b0;
            cs_wait_q     <= 1'b1;
            data_out_q    <= 16'h0000;
            frame_valid_q <= 1'b0;
            frame_ch_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_cmd_q     <= 1'b0;
            err_sel_q     <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            clk_prev_q    <= clk_prev_d;
            cs_wait_q     <= cs_wait_d;
            data_out_q    <= data_out_d;
            frame_valid_q <= frame_valid_d;
            frame_ch_q    <= frame_ch_d;
            err_len_q     <= err_len_d;
            err_cmd_q     <= err_cmd_d;
            err_sel_q     <= err_sel_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_ch    = frame_ch_q;
    assign err_len     = err_len_q;
    assign err_cmd     = err_cmd_q;
    assign err_sel     = err_sel_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_frame_rx
//  Purpose  : Self-checking bench for dac_frame_rx: directed vector table,
//             hand-written select/reset sequences, and randomized frames
//             checked against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_frame_rx;

    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] CMD0        = 4'b0111;
    localparam logic [3:0] CMD1        = 4'b1111;
    localparam int         HALF        = 3;   // ClkDac half period in clk cycles

    logic        clk;
    logic        CS;
    logic        ClkDac;
    logic [1:0]  CsDac;
    logic        dataDac;
    logic        err_clr;
    logic [15:0] data_out;
    logic        frame_valid;
    logic        frame_ch;
    logic        err_len;
    logic        err_cmd;
    logic        err_sel;
    logic [7:0]  frame_cnt;

    dac_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .CMD0        (CMD0),
        .CMD1        (CMD1)
    ) u_dut (
        .clk         (clk),
        .CS          (CS),
        .ClkDac      (ClkDac),
        .CsDac       (CsDac),
        .dataDac     (dataDac),
        .err_clr     (err_clr),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_ch    (frame_ch),
        .err_len     (err_len),
        .err_cmd     (err_cmd),
        .err_sel     (err_sel),
        .frame_cnt   (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running count of frame_valid high samples.
    int pulse_total = 0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) pulse_total++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (frame-level, not cycle-level).
    logic [15:0] m_data;
    logic        m_ch;
    logic [7:0]  m_cnt;
    logic        m_len, m_cmd, m_sel;

    typedef struct {
        logic        ch;
        logic [15:0] word;
        int          nbits;
        logic        clr;
        logic [15:0] e_data;
        logic        e_ch;
        logic [7:0]  e_cnt;
        logic        e_len;
        logic        e_cmd;
        int          e_p;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dac_bit(input logic b);
        dataDac = b;
        ClkDac  = 1'b0;
        wait_clk(HALF);
        ClkDac  = 1'b1;
        wait_clk(HALF);
        ClkDac  = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] word, input int nbits);
        logic [15:0] w;
        w = word;
        for (int i = 0; i < nbits; i++) begin
            dac_bit(w[15]);
            w = w << 1;
        end
    endtask

    task automatic send_frame(input logic ch, input logic [15:0] word, input int nbits,
                              output int pulses);
        int p0;
        p0    = pulse_total;
        CsDac = ch ? 2'b10 : 2'b01;
        wait_clk(HALF);
        send_bits(word, nbits);
        wait_clk(HALF);
        CsDac = 2'b00;
        wait_clk(12);
        pulses = pulse_total - p0;
    endtask

    function automatic int model_frame(input logic ch, input logic [15:0] word, input int nbits);
        logic [3:0] cmd;
        cmd = ch ? CMD1 : CMD0;
        if (nbits != 16) begin
            m_len = 1'b1;
            return 0;
        end
        if (word[15:12] != cmd || word[3:0] != 4'h0) begin
            m_cmd = 1'b1;
            return 0;
        end
        if (ch) m_data[15:8] = word[11:4];
        else    m_data[7:0]  = word[11:4];
        m_ch  = ch;
        m_cnt = m_cnt + 8'd1;
        return 1;
    endfunction

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        m_len = 1'b0;
        m_cmd = 1'b0;
        m_sel = 1'b0;
    endtask

    task automatic check_model(input string tag, input int got_p, input int exp_p);
        check({tag, " data_out"}, 32'(data_out), 32'(m_data));
        check({tag, " frame_ch"}, 32'(frame_ch), 32'(m_ch));
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
        check({tag, " err_len"}, 32'(err_len), 32'(m_len));
        check({tag, " err_cmd"}, 32'(err_cmd), 32'(m_cmd));
        check({tag, " err_sel"}, 32'(err_sel), 32'(m_sel));
        check({tag, " pulses"}, 32'(got_p), 32'(exp_p));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out"}, 32'(data_out), 32'h0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, " frame_ch"}, 32'(frame_ch), 32'h0);
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'h0);
        check({tag, " errs"}, 32'({err_len, err_cmd, err_sel}), 32'h0);
    endtask

    initial begin
        int          p;
        int          ep;
        logic        ch;
        logic [15:0] w;
        int          nb;
        int          kind;
        int          p0;

        CS      = 1'b0;
        ClkDac  = 1'b0;
        CsDac   = 2'b00;
        dataDac = 1'b0;
        err_clr = 1'b0;
        m_data  = 16'h0000;
        m_ch    = 1'b0;
        m_cnt   = 8'd0;
        m_len   = 1'b0;
        m_cmd   = 1'b0;
        m_sel   = 1'b0;

        vecs[0] = '{1'b0, 16'h7A50, 16, 1'b0, 16'h00A5, 1'b0, 8'd1, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 16'hF3C0, 16, 1'b0, 16'h3CA5, 1'b1, 8'd2, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 16'h7A50, 15, 1'b0, 16'h3CA5, 1'b1, 8'd2, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b0, 16'h7A50, 17, 1'b1, 16'h3CA5, 1'b1, 8'd2, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 16'h7120, 16, 1'b0, 16'h3CA5, 1'b1, 8'd2, 1'b0, 1'b1, 0};
        vecs[5] = '{1'b0, 16'h7A51, 16, 1'b1, 16'h3CA5, 1'b1, 8'd2, 1'b0, 1'b1, 0};
        vecs[6] = '{1'b0, 16'h7120, 16, 1'b0, 16'h3C12, 1'b0, 8'd3, 1'b0, 1'b0, 1};

        // Reset state
        wait_clk(3);
        check_reset_outputs("reset");
        CS = 1'b1;
        wait_clk(4);
        check_reset_outputs("post_reset");

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].ch, vecs[i].word, vecs[i].nbits, p);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_data));
            check($sformatf("vec%0d frame_ch", i), 32'(frame_ch), 32'(vecs[i].e_ch));
            check($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d err_len", i), 32'(err_len), 32'(vecs[i].e_len));
            check($sformatf("vec%0d err_cmd", i), 32'(err_cmd), 32'(vecs[i].e_cmd));
            check($sformatf("vec%0d err_sel", i), 32'(err_sel), 32'h0);
            check($sformatf("vec%0d pulses", i), 32'(p), 32'(vecs[i].e_p));
            ep = model_frame(vecs[i].ch, vecs[i].word, vecs[i].nbits);
            if (vecs[i].clr) pulse_clr();
        end

        // Both selects high in idle, with err_clr pulsed while still high
        p0    = pulse_total;
        CsDac = 2'b11;
        wait_clk(8);
        m_sel = 1'b1;
        check_model("sel11", pulse_total - p0, 0);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(2);
        check("sel11 clr_vs_set err_sel", 32'(err_sel), 32'h1);
        CsDac = 2'b00;
        wait_clk(6);
        send_frame(1'b1, 16'hFAB0, 16, p);
        ep = model_frame(1'b1, 16'hFAB0, 16);
        check_model("after_sel11", p, ep);
        pulse_clr();

        // Select switches 01 -> 10 mid-frame
        p0    = pulse_total;
        CsDac = 2'b01;
        wait_clk(HALF);
        send_bits(16'h7A50, 8);
        CsDac = 2'b10;
        send_bits(16'hF000, 4);
        wait_clk(HALF);
        CsDac = 2'b00;
        wait_clk(12);
        m_sel = 1'b1;
        check_model("sel_switch", pulse_total - p0, 0);
        send_frame(1'b0, 16'h7550, 16, p);
        ep = model_frame(1'b0, 16'h7550, 16);
        check_model("after_switch", p, ep);
        pulse_clr();

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            ch   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
            w    = {(ch ? CMD1 : CMD0), 8'($urandom), 4'h0};
            if (kind == 2) w[15:12] = 4'($urandom);
            if (kind == 3) w[3:0]   = 4'($urandom);
            case ($urandom_range(0, 5))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            send_frame(ch, w, nb, p);
            ep = model_frame(ch, w, nb);
            check_model($sformatf("rnd%0d", i), p, ep);
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end

        // Reset mid-frame; select still high at release must not start a frame
        CsDac = 2'b01;
        wait_clk(HALF);
        send_bits(16'h7A50, 8);
        CS = 1'b0;
        wait_clk(2);
        check_reset_outputs("midframe_reset");
        CS = 1'b1;
        wait_clk(3);
        p0 = pulse_total;
        send_bits(16'hA500, 8);
        wait_clk(HALF);
        CsDac = 2'b00;
        wait_clk(12);
        m_data = 16'h0000;
        m_ch   = 1'b0;
        m_cnt  = 8'd0;
        m_len  = 1'b0;
        m_cmd  = 1'b0;
        m_sel  = 1'b0;
        check_model("partial_dropped", pulse_total - p0, 0);

        // 256 good frames: counter wraps to 0
        p0 = pulse_total;
        for (int i = 0; i < 256; i++) begin
            ch = 1'($urandom_range(0, 1));
            w  = {(ch ? CMD1 : CMD0), 8'($urandom), 4'h0};
            send_frame(ch, w, 16, p);
            ep = model_frame(ch, w, 16);
            if (i == 254) check("cnt_255", 32'(frame_cnt), 32'd255);
        end
        check_model("wrap", pulse_total - p0, 256);
        check("wrap frame_cnt_zero", 32'(frame_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
